spi_master_core: RTL and testbench

SPI_MASTER_CORE -- requirements
Module: spi_master_core

---
 rtl/spi_master_core.sv | 151 +++++++++++++++
 tb/tb_spi_master_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// Single-byte SPI master: MSB-first, CPOL/CPHA selectable, programmable SCK divider.
// One transfer per rising of the enable while the slave is selected; abortable mid-byte.
module spi_master_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_m,
  input  logic [7:0] spcon,
  input  logic [7:0] spibr,
  input  logic [7:0] spssn,
  output logic [7:0] data_r_m,
  input  logic       miso,
  output logic       mosi,
  output logic       sck,
  output logic       ssn
);

  typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_armed;
  logic [7:0] r_shift;
  logic [7:0] r_div;
  logic [7:0] r_br;
  logic [3:0] r_edge;
  logic       r_cpha;
  logic       r_rx_bit;
  logic       r_sck;
  logic       r_mosi;
  logic       r_ssn;
  logic [7:0] r_data_r;

  logic w_spen;
  logic w_sel;
  logic w_start;
  logic w_abort;
  logic w_tc;
  logic w_lead;
  logic w_trail;
  logic w_last;
  logic w_rx_in;
  logic w_unused;

  assign w_spen   = spcon[0];
  assign w_sel    = ~spssn[0];
  assign w_unused = ^{spcon[7:3], spssn[7:1]};

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_abort = 1'b0;
    w_tc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_spen && w_sel && r_armed) begin
          w_start = 1'b1;
          w_next  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!w_spen || !w_sel) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (r_div == r_br) begin
          w_tc = 1'b1;
          if (r_edge == 4'd15) w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Even edge indices are leading SCK edges, odd ones trailing.
  assign w_lead  = w_tc & ~r_edge[0];
  assign w_trail = w_tc &  r_edge[0];
  assign w_last  = w_tc & (r_edge == 4'd15);
  // CPHA=0 samples on the leading edge and shifts on the trailing one; CPHA=1 samples and shifts together.
  assign w_rx_in = r_cpha ? miso : r_rx_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_armed <= 1'b1;
    else if (!w_spen) r_armed <= 1'b1;
    else if (w_start) r_armed <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ssn <= 1'b1;
    else     r_ssn <= spssn[0];
  end

  // Clock generation: configuration is frozen at start so mid-transfer writes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck  <= 1'b0;
      r_div  <= 8'd0;
      r_edge <= 4'd0;
      r_br   <= 8'd0;
      r_cpha <= 1'b0;
    end else if (w_start) begin
      r_sck  <= spcon[2];
      r_div  <= 8'd0;
      r_edge <= 4'd0;
      r_br   <= spibr;
      r_cpha <= spcon[1];
    end else if (r_state == ST_XFER && !w_abort) begin
      if (w_tc) begin
        r_div  <= 8'd0;
        r_edge <= r_edge + 4'd1;
        r_sck  <= ~r_sck;
      end else begin
        r_div  <= r_div + 8'd1;
      end
    end else begin
      r_div <= 8'd0;
      r_sck <= spcon[2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= 8'd0;
      r_mosi   <= 1'b0;
      r_rx_bit <= 1'b0;
      r_data_r <= 8'd0;
    end else if (w_start) begin
      r_shift <= data_m;
      if (!spcon[1]) r_mosi <= data_m[7];
    end else begin
      if (w_lead) begin
        if (r_cpha) r_mosi   <= r_shift[7];
        else        r_rx_bit <= miso;
      end
      if (w_trail) begin
        r_shift <= {r_shift[6:0], w_rx_in};
        if (!r_cpha && !w_last) r_mosi <= r_shift[6];
      end
      if (w_last) r_data_r <= {r_shift[6:0], w_rx_in};
    end
  end

  assign sck      = r_sck;
  assign mosi     = r_mosi;
  assign ssn      = r_ssn;
  assign data_r_m = r_data_r;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core with a per-cycle transfer-level reference model.
module tb_spi_master_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_m = 8'h00;
  logic [7:0] spcon  = 8'h00;
  logic [7:0] spibr  = 8'h00;
  logic [7:0] spssn  = 8'hFF;
  logic [7:0] data_r_m;
  logic       miso;
  logic       mosi;
  logic       sck;
  logic       ssn;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave / loopback selection and sck edge bookkeeping
  logic       use_slave  = 1'b0;
  logic [7:0] slave_tx   = 8'h00;
  int         slave_base = 0;
  int         slave_idx;
  int         rise_cnt = 0;
  int         fall_cnt = 0;
  time        last_rise = 0;
  time        rise_period = 0;
  logic [31:0] mosi_hist = 32'd0;

  // Reference model state
  logic [7:0] exp_rx  = 8'h00;
  logic       m_x     = 1'b0;
  logic       m_armed = 1'b1;
  logic       m_sck   = 1'b0;
  logic       m_mosi  = 1'b0;
  logic       m_ssn   = 1'b1;
  logic [7:0] m_rx    = 8'h00;
  logic [7:0] m_data  = 8'h00;
  logic       m_cpol  = 1'b0;
  logic       m_cpha  = 1'b0;
  int         m_b     = 0;
  int         m_t     = 0;

  int r0, r1, f0;

  spi_master_core dut (
    .clk      (clk),
    .rst      (rst),
    .data_m   (data_m),
    .spcon    (spcon),
    .spibr    (spibr),
    .spssn    (spssn),
    .data_r_m (data_r_m),
    .miso     (miso),
    .mosi     (mosi),
    .sck      (sck),
    .ssn      (ssn)
  );

  always #5 clk = ~clk;

  always_comb begin
    slave_idx = fall_cnt - slave_base;
    miso = mosi;
    if (use_slave) miso = (slave_idx >= 0 && slave_idx < 8) ? slave_tx[7 - slave_idx] : 1'b0;
  end

  always @(posedge sck) begin
    rise_cnt    <= rise_cnt + 1;
    rise_period <= $time - last_rise;
    last_rise   <= $time;
    mosi_hist   <= {mosi_hist[30:0], mosi};
  end

  always @(negedge sck) fall_cnt <= fall_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    int e;
    int idx;
    if (rst) begin
      m_x = 1'b0; m_armed = 1'b1; m_sck = 1'b0; m_mosi = 1'b0; m_ssn = 1'b1; m_rx = 8'h00; m_t = 0;
    end else begin
      m_ssn = spssn[0];
      if (m_x) begin
        if (!spcon[0] || spssn[0]) begin
          m_x   = 1'b0;
          m_sck = spcon[2];
        end else begin
          m_t++;
          if (m_t % (m_b + 1) == 0) begin
            e     = m_t / (m_b + 1);
            m_sck = m_cpol ^ e[0];
            if (!m_cpha) idx = (e / 2 > 7) ? 7 : e / 2;
            else         idx = (e - 1) / 2;
            m_mosi = m_data[7 - idx];
            if (e == 16) begin
              m_x  = 1'b0;
              m_rx = exp_rx;
            end
          end
        end
      end else if (spcon[0] && !spssn[0] && m_armed) begin
        m_x = 1'b1; m_t = 0; m_b = int'(spibr); m_cpol = spcon[2]; m_cpha = spcon[1];
        m_data = data_m; m_armed = 1'b0; m_sck = spcon[2];
        if (!spcon[1]) m_mosi = data_m[7];
      end else begin
        m_sck = spcon[2];
      end
      if (!spcon[0]) m_armed = 1'b1;
    end
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        model_step();
      end
      forever begin
        @(negedge clk);
        check("sck", 32'(sck), 32'(m_sck));
        check("mosi", 32'(mosi), 32'(m_mosi));
        check("ssn", 32'(ssn), 32'(m_ssn));
        check("data_r_m", 32'(data_r_m), 32'(m_rx));
      end
    join_none

    // Reset values
    tick(3);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ssn", 32'(ssn), 32'd1);
    check("rst_data", 32'(data_r_m), 32'h00);
    rst = 1'b0;
    tick(3);
    check("ssn_after_rst", 32'(ssn), 32'd1);

    // Mode 0 loopback, spibr=2
    spibr = 8'd2; data_m = 8'hA5; exp_rx = 8'hA5; spssn = 8'hFE;
    tick(2);
    r0 = rise_cnt;
    spcon = 8'h01;
    tick(60);
    check("m0_data", 32'(data_r_m), 32'hA5);
    check("m0_model_rx", 32'(m_rx), 32'hA5);
    check("m0_pulses", 32'(rise_cnt - r0), 32'd8);
    check("m0_period", 32'(rise_period), 32'd60);
    spcon = 8'h00; spssn = 8'hFF;
    tick(3);

    // Mode 0 against a slave returning 8'h3C
    use_slave = 1'b1; slave_tx = 8'h3C; slave_base = fall_cnt;
    exp_rx = 8'h3C; data_m = 8'hA5; spssn = 8'hFE;
    tick(2);
    spcon = 8'h01;
    tick(60);
    check("slave_data", 32'(data_r_m), 32'h3C);
    check("slave_rx", 32'(mosi_hist[7:0]), 32'hA5);
    spcon = 8'h00; spssn = 8'hFF; use_slave = 1'b0;
    tick(3);

    // CPOL=1 CPHA=1, spibr=0 loopback
    spibr = 8'd0; data_m = 8'h5A; exp_rx = 8'h5A; spcon = 8'h06; spssn = 8'hFE;
    tick(3);
    check("m3_idle_sck", 32'(sck), 32'd1);
    r0 = rise_cnt;
    spcon = 8'h07;
    tick(40);
    check("m3_data", 32'(data_r_m), 32'h5A);
    check("m3_pulses", 32'(rise_cnt - r0), 32'd8);
    check("m3_period", 32'(rise_period), 32'd20);
    check("m3_end_sck", 32'(sck), 32'd1);

    // Abort after three SCK periods
    spcon = 8'h00; spibr = 8'd2; data_m = 8'hC3; exp_rx = 8'hC3;
    tick(3);
    f0 = fall_cnt; r0 = rise_cnt;
    spcon = 8'h01;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (fall_cnt - f0 >= 3) break;
    end
    check("abort_reached", 32'(fall_cnt - f0 >= 3), 32'd1);
    spssn = 8'hFF;
    tick(1);
    check("abort_sck", 32'(sck), 32'd0);
    r1 = rise_cnt;
    tick(40);
    check("abort_rises", 32'(r1 - r0), 32'd3);
    check("abort_no_edges", 32'(rise_cnt - r1), 32'd0);
    check("abort_data", 32'(data_r_m), 32'h5A);

    // Enable held high: one transfer only, re-arm starts another
    spcon = 8'h00; spssn = 8'hFE; data_m = 8'h96; exp_rx = 8'h96;
    tick(3);
    r0 = rise_cnt;
    spcon = 8'h01;
    tick(200);
    check("hold_one_xfer", 32'(rise_cnt - r0), 32'd8);
    check("hold_data", 32'(data_r_m), 32'h96);
    data_m = 8'h69; exp_rx = 8'h69; spcon = 8'h00;
    tick(1);
    spcon = 8'h01;
    tick(60);
    check("rearm_pulses", 32'(rise_cnt - r0), 32'd16);
    check("rearm_data", 32'(data_r_m), 32'h69);
    check("rearm_model_rx", 32'(m_rx), 32'h69);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
